// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per
// clock, using a single full adder and a small IDLE/RUN/DONE controller.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             c_nx;
    logic [WIDTH-1:0] psum_nx;

    // Full adder on the current LSBs; the new sum bit enters the partial sum at the top
    always_comb begin
        s       = opa[0] ^ opb[0] ^ carry;
        c_nx    = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
        psum_nx = psum >> 1;
        psum_nx[WIDTH-1] = s;
    end

    // Controller plus datapath registers; busy/done are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            opa   <= '0;
            opb   <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        psum  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    psum  <= psum_nx;
                    carry <= c_nx;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= psum_nx;
                        cout  <= c_nx;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        done  <= 1'b0;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
